// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg -- shared 8N1 frame constants, FSM state types, divisor clamp.
// Revision: 1.0
// ============================================================================
package uart_pkg;

  localparam int          DATA_BITS = 8;
  localparam int          STOP_BITS = 1;
  localparam logic [15:0] MIN_DIV   = 16'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx -- 8N1 receiver: falling-edge start detect, mid-bit sampling.
// Revision: 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] div,
  input  logic        rx_in,
  output logic [7:0]  rx_data,
  output logic        rx_ready
);

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        prev_q, prev_d;
  logic [15:0] half_m1;
  logic [15:0] full_m1;

  always_comb begin
    half_m1  = {1'b0, div[15:1]} - 16'd1;
    full_m1  = div - 16'd1;
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    prev_d   = rx_in;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_in) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line halfway into the start bit to reject glitches.
        if (cnt_q >= half_m1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_in ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q >= full_m1) begin
          cnt_d   = '0;
          shift_d = {rx_in, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
          else                            bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q >= full_m1) begin
          cnt_d = '0;
          if (rx_in) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_in) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_ready = ready_q;

endmodule
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
// uart_top -- full-duplex 8N1 UART, shared baud divisor; TX + baud gen inline.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx.  Revision: 1.0
// ============================================================================
module uart_top
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_divisor,
  input  logic [7:0]  tx_data,
  input  logic        tx_start,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_ready
);

  logic [15:0] div_eff;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        tx_tick;

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_done_q, tx_done_d;
  logic        rx_in;

  always_comb begin
    div_eff    = eff_div(baud_divisor);
    tx_tick    = (baud_cnt_q == div_q - 16'd1);
    // Divisor is only re-latched at wrap so a bit period is never cut short.
    baud_cnt_d = tx_tick ? 16'd0 : baud_cnt_q + 16'd1;
    div_d      = tx_tick ? div_eff : div_q;

    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_busy_q) begin
          if (tx_tick) begin
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end
        end else if (tx_start) begin
          tx_shift_d = tx_data;
          tx_busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
            tx_bit_d   = '0;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_bit_q == 3'(STOP_BITS - 1)) begin
            tx_state_d = TX_IDLE;
            tx_busy_d  = 1'b0;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= div_eff;
      baud_cnt_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

`ifdef UART_RX_SYNC_EN
  logic rx_s1_q, rx_s1_d;
  logic rx_s2_q, rx_s2_d;

  always_comb begin
    rx_s1_d = rx;
    rx_s2_d = rx_s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
    end
  end

  assign rx_in = rx_s2_q;
`else
  assign rx_in = rx;
`endif

  uart_rx u_rx (
    .clk      (clk),
    .reset    (reset),
    .div      (div_eff),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
// tb_uart_top -- loopback bench for uart_top with an expected-byte scoreboard.
// Revision: 1.0
// ============================================================================
module tb_uart_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] baud_divisor = 16'd32;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_start = 1'b0;
  logic        tx, tx_busy, tx_done;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        link = 1'b1;
  logic        rx_force = 1'b1;

  assign rx = link ? tx : rx_force;

  uart_top dut (
    .clk          (clk),
    .reset        (reset),
    .baud_divisor (baud_divisor),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready)
  );

  always #10 clk = ~clk;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] got_q[$];
  int         got_t[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_ready === 1'b1) begin
      got_q.push_back(rx_data);
      got_t.push_back(cyc);
    end
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (tx_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      ok = 1'b0;
      return;
    end
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    exp_q.push_back(b);
    exp_t.push_back(cyc);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset;
    bit bad = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    reset = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || rx_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL idle_quiet: got activity want tx=1 busy=0 rx_ready=0"); end
  endtask

  task automatic test_single;
    logic [7:0] b = 8'hA5;
    logic [7:0] g;
    bit ok;
    int n = 0;
    int lowc = 0;
    int d0 = done_cnt;
    while (dut.tx_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    send_byte(b, ok);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (!ok || tx !== 1'b0) begin errors++; $display("FAIL start_seen: got tx=%b want 0", tx); end
    while (tx === 1'b0 && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    checks++; if (lowc != 32) begin errors++; $display("FAIL start_len: got %0d want 32", lowc); end
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? 16 : 32) @(negedge clk);
      checks++;
      if (tx !== b[i]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", i, tx, b[i]); end
    end
    repeat (32) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL stop_bit: got %b want 1", tx); end
    wait_rx(1, 100, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_rx: got no rx_ready want A5");
    end else begin
      g = got_q.pop_front();
      void'(got_t.pop_front());
      if (g !== exp_q.pop_front()) begin errors++; $display("FAIL single_rx: got %h want a5", g); end
      void'(exp_t.pop_front());
    end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v[3] = '{8'hC7, 8'h11, 8'hFA};
    logic [7:0] g, e;
    int gt, et;
    bit ok;
    int d0 = done_cnt;
    for (int i = 0; i < 3; i++) send_byte(v[i], ok);
    wait_rx(3, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); gt = got_t.pop_front();
      e = exp_q.pop_front(); et = exp_t.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", g, e); end
      checks++; if (gt - et > 500) begin errors++; $display("FAIL b2b_latency: got %0d clks want <=500", gt - et); end
    end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != d0 + 3) begin errors++; $display("FAIL b2b_done: got %0d want 3", done_cnt - d0); end
    exp_q.delete(); exp_t.delete();
  endtask

  task automatic test_busy_ignore;
    logic [7:0] g;
    bit ok;
    int d0 = done_cnt;
    send_byte(8'h3C, ok);
    repeat (100) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b want 1", tx_busy); end
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_rx(1, 600, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL busy_rx: got no rx_ready want 3c");
    end else begin
      g = got_q.pop_front();
      void'(got_t.pop_front());
      if (g !== exp_q.pop_front()) begin errors++; $display("FAIL busy_rx: got %h want 3c", g); end
      void'(exp_t.pop_front());
    end
    repeat (400) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL busy_extra: got %0d extra bytes want 0", got_q.size()); end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL busy_done: got %0d want 1", done_cnt - d0); end
    got_q.delete(); got_t.delete();
  endtask

  task automatic test_glitch;
    logic [7:0] g;
    bit ok;
    link = 1'b0;
    rx_force = 1'b1;
    repeat (5) @(negedge clk);
    rx_force = 1'b0;
    repeat (5) @(negedge clk);
    rx_force = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_reject: got %0d bytes want 0", got_q.size()); end
    got_q.delete(); got_t.delete();
    link = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h5A, ok);
    wait_rx(1, 600, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL glitch_next: got no rx_ready want 5a");
    end else begin
      g = got_q.pop_front();
      void'(got_t.pop_front());
      if (g !== exp_q.pop_front()) begin errors++; $display("FAIL glitch_next: got %h want 5a", g); end
      void'(exp_t.pop_front());
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    bit ok;
    send_byte(8'h96, ok);
    repeat (120) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", tx_busy); end
    reset = 1'b1;
    exp_q.delete(); exp_t.delete();
    repeat (500) @(negedge clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midreset_rx: got %0d bytes want 0", got_q.size()); end
    got_q.delete(); got_t.delete();
  endtask

  task automatic test_random;
    logic [7:0] g, e;
    bit ok;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), ok);
    wait_rx(10, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_count: got %0d want 10", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); void'(got_t.pop_front());
      e = exp_q.pop_front(); void'(exp_t.pop_front());
      checks++; if (g !== e) begin errors++; $display("FAIL rand_data: got %h want %h", g, e); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_busy_ignore;
    test_glitch;
    test_reset_midframe;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
